// File: rtl/gb_cart_bus_master.sv
// Host-side Game Boy cartridge bus initiator: turns single-beat read/write requests
// into 4-cycle cart bus accesses (P0..P3) with PHI = gb_clk/4.
module gb_cart_bus_master #(
  parameter bit          PHI_ALIGN  = 1'b1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        gb_clk,
  input  logic        i_resetn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [15:0] i_req_addr,
  input  logic [7:0]  i_req_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic        o_cart_clk,
  output logic [15:0] o_cart_a,
  output logic [7:0]  o_cart_d_out,
  output logic        o_cart_d_oe,
  input  logic [7:0]  i_cart_d_in,
  output logic        o_cart_nRD,
  output logic        o_cart_nWR,
  output logic        o_cart_nCS
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  gap_q, gap_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        accept;
  logic        sel;

  // Ready is forced low while reset is held so no request can be taken then.
  always_comb begin
    o_req_ready = i_resetn && (state_q == S_IDLE) && (gap_q == '0) &&
                  (!PHI_ALIGN || (phase_q == 2'd3));
  end

  assign accept = i_req_valid && o_req_ready;

  // RAM/IO chip select window; ROM is addressed purely through A15.
  assign sel = (addr_q >= 16'hA000) && (addr_q <= 16'hFDFF);

  // State register
  always_ff @(posedge gb_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_P0;
      S_P0:    state_d = S_P1;
      S_P1:    state_d = S_P2;
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Cart bus outputs, decoded from state and the latched request
  always_comb begin
    o_cart_a    = {1'b1, addr_q[14:0]};
    o_cart_nRD  = 1'b0;
    o_cart_nWR  = 1'b1;
    o_cart_nCS  = 1'b1;
    o_cart_d_oe = 1'b0;
    unique case (state_q)
      S_P0: begin
        o_cart_nRD  = we_q;
        o_cart_d_oe = we_q;
      end
      S_P1: begin
        o_cart_a[15] = addr_q[15];
        o_cart_nRD   = we_q;
        o_cart_d_oe  = we_q;
        o_cart_nCS   = !sel;
      end
      S_P2, S_P3: begin
        o_cart_a[15] = addr_q[15];
        o_cart_nRD   = we_q;
        o_cart_d_oe  = we_q;
        o_cart_nCS   = !sel;
        o_cart_nWR   = !we_q;
      end
      default: ;
    endcase
  end

  // Write data stays on d_out after the access ends, giving hold time past nWR rise.
  assign o_cart_d_out = wdata_q;
  assign o_cart_clk   = phase_q[1];
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_rdata  = rdata_q;

  // Datapath next-state
  always_comb begin
    phase_d     = phase_q + 2'd1;
    gap_d       = gap_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    if (state_q == S_IDLE && gap_q != '0) begin
      gap_d = gap_q - 3'd1;
    end
    if (accept) begin
      we_d   = i_req_we;
      addr_d = i_req_addr;
      if (i_req_we) begin
        wdata_d = i_req_wdata;
      end
    end
    if (state_q == S_P3) begin
      rsp_valid_d = 1'b1;
      rdata_d     = we_q ? 8'h00 : i_cart_d_in;
      gap_d       = 3'(GAP_CYCLES);
    end
  end

  always_ff @(posedge gb_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      phase_q     <= '0;
      gap_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '1;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      gap_q       <= gap_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Scoreboard bench for gb_cart_bus_master (PHI_ALIGN=1, GAP_CYCLES=1).
module tb_gb_cart_bus_master;

  logic        gb_clk = 1'b0;
  logic        i_resetn;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [15:0] i_req_addr;
  logic [7:0]  i_req_wdata;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_rdata;
  logic        o_cart_clk;
  logic [15:0] o_cart_a;
  logic [7:0]  o_cart_d_out;
  logic        o_cart_d_oe;
  logic [7:0]  i_cart_d_in;
  logic        o_cart_nRD;
  logic        o_cart_nWR;
  logic        o_cart_nCS;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
  } exp_t;
  exp_t expq[$];

  gb_cart_bus_master #(.PHI_ALIGN(1'b1), .GAP_CYCLES(1)) dut (
    .gb_clk       (gb_clk),
    .i_resetn     (i_resetn),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_cart_clk   (o_cart_clk),
    .o_cart_a     (o_cart_a),
    .o_cart_d_out (o_cart_d_out),
    .o_cart_d_oe  (o_cart_d_oe),
    .i_cart_d_in  (i_cart_d_in),
    .o_cart_nRD   (o_cart_nRD),
    .o_cart_nWR   (o_cart_nWR),
    .o_cart_nCS   (o_cart_nCS)
  );

  always #5 gb_clk = ~gb_clk;
  always @(posedge gb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted request pushes its expected response.
  always @(negedge gb_clk) begin
    if (i_resetn && i_req_valid && o_req_ready) begin
      expq.push_back('{rdata: (i_req_we ? 8'h00 : i_cart_d_in), cyc: cyc});
    end
  end

  // Monitor: pops and compares on each response pulse.
  always @(negedge gb_clk) begin
    if (i_resetn && o_rsp_valid) begin
      exp_t e;
      rsp_cnt++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=0x%0h expected no response", o_rsp_rdata);
      end else begin
        e = expq.pop_front();
        chk("rsp_rdata", 32'(o_rsp_rdata), 32'(e.rdata));
        chk("rsp_latency", 32'(cyc - e.cyc), 32'd5);
      end
    end
  end

  // Presents a request and returns one cycle after acceptance (inside P0).
  task automatic start_req(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                           input logic [7:0] drv, output bit ok);
    int n = 0;
    @(posedge gb_clk); #1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wd;
    i_cart_d_in = drv;
    i_req_valid = 1'b1;
    @(negedge gb_clk);
    while (!o_req_ready && n < 40) begin
      @(negedge gb_clk);
      n++;
    end
    ok = o_req_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 for 40 cycles expected ready=1");
      i_req_valid = 1'b0;
      return;
    end
    chk("accept_phi_high", 32'(o_cart_clk), 32'd1);
    @(posedge gb_clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic chk_bus(input string ph, input logic [15:0] a, input bit nrd, input bit nwr,
                         input bit ncs, input bit oe);
    chk({ph, "_a"},    32'(o_cart_a),    32'(a));
    chk({ph, "_nRD"},  32'(o_cart_nRD),  32'(nrd));
    chk({ph, "_nWR"},  32'(o_cart_nWR),  32'(nwr));
    chk({ph, "_nCS"},  32'(o_cart_nCS),  32'(ncs));
    chk({ph, "_d_oe"}, 32'(o_cart_d_oe), 32'(oe));
  endtask

  // Full access with hand-computed bus expectations: a0 in P0, a1 in P1..P3.
  task automatic access(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] drv, input logic [15:0] a0, input logic [15:0] a1,
                        input bit cs);
    bit ok;
    start_req(we, addr, wd, drv, ok);
    if (!ok) return;
    @(negedge gb_clk);
    chk_bus("P0", a0, we, 1'b1, 1'b1, we);
    chk("P0_phi", 32'(o_cart_clk), 32'd0);
    chk("P0_ready", 32'(o_req_ready), 32'd0);
    if (we) chk("P0_d_out", 32'(o_cart_d_out), 32'(wd));
    @(negedge gb_clk);
    chk_bus("P1", a1, we, 1'b1, !cs, we);
    @(negedge gb_clk);
    chk_bus("P2", a1, we, !we, !cs, we);
    @(negedge gb_clk);
    chk_bus("P3", a1, we, !we, !cs, we);
    if (we) chk("P3_d_out", 32'(o_cart_d_out), 32'(wd));
    @(negedge gb_clk);
    chk_bus("C5", a0, 1'b0, 1'b1, 1'b1, 1'b0);
    if (we) chk("C5_d_hold", 32'(o_cart_d_out), 32'(wd));
  endtask

  initial begin
    int acc[3];
    int k;
    int rdy;
    bit ok;
    i_resetn    = 1'b0;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = 16'h0000;
    i_req_wdata = 8'h00;
    i_cart_d_in = 8'h00;

    repeat (3) @(negedge gb_clk);
    chk_bus("reset", 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("reset_d_out", 32'(o_cart_d_out), 32'd0);
    chk("reset_phi", 32'(o_cart_clk), 32'd0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_rdata", 32'(o_rsp_rdata), 32'd0);
    chk("reset_ready", 32'(o_req_ready), 32'd0);
    @(posedge gb_clk); #1;
    i_resetn = 1'b1;

    access(1'b1, 16'h4000, 8'h10, 8'hEE, 16'hC000, 16'h4000, 1'b0);
    access(1'b1, 16'hA001, 8'h80, 8'hEE, 16'hA001, 16'hA001, 1'b1);
    access(1'b0, 16'hA000, 8'h00, 8'h5A, 16'hA000, 16'hA000, 1'b1);
    access(1'b0, 16'h0150, 8'h00, 8'h3C, 16'h8150, 16'h0150, 1'b0);
    access(1'b0, 16'h8000, 8'h00, 8'hC3, 16'h8000, 16'h8000, 1'b0);

    // Valid held across three requests: accepts must land exactly 8 cycles apart.
    @(posedge gb_clk); #1;
    i_req_we    = 1'b0;
    i_req_addr  = 16'hA000;
    i_cart_d_in = 8'h77;
    i_req_valid = 1'b1;
    k = 0;
    rdy = 0;
    for (int n = 0; n < 60 && k < 3; n++) begin
      @(negedge gb_clk);
      if (o_req_ready) begin
        rdy++;
        acc[k] = cyc;
        k++;
      end
    end
    @(posedge gb_clk); #1;
    i_req_valid = 1'b0;
    chk("b2b_accepts", 32'(k), 32'd3);
    chk("b2b_ready_cycles", 32'(rdy), 32'd3);
    chk("b2b_spacing_1", 32'(acc[1] - acc[0]), 32'd8);
    chk("b2b_spacing_2", 32'(acc[2] - acc[1]), 32'd8);
    repeat (8) @(negedge gb_clk);

    // Reset during P2 of a write drops the access with no response.
    start_req(1'b1, 16'h4000, 8'h10, 8'h00, ok);
    @(negedge gb_clk);
    @(negedge gb_clk);
    @(negedge gb_clk);
    chk("rst_pre_nWR", 32'(o_cart_nWR), 32'd0);
    #2 i_resetn = 1'b0;
    #1;
    chk_bus("rst_mid", 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_mid_ready", 32'(o_req_ready), 32'd0);
    expq.delete();
    repeat (3) @(negedge gb_clk);
    @(posedge gb_clk); #1;
    i_resetn = 1'b1;
    access(1'b0, 16'hA000, 8'h00, 8'h5A, 16'hA000, 16'hA000, 1'b1);

    repeat (10) @(negedge gb_clk);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    chk("rsp_count", 32'(rsp_cnt), 32'd9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
